// File: rtl/mem_access_unit_if.sv
// Request/acknowledge bus between the memory-stage access controller and the data memory.
interface mem_access_unit_if;
  logic        dmemReq;
  logic        dmemWe;
  logic [63:0] dmemAddr;
  logic [63:0] dmemWData;
  logic [63:0] dmemRData;
  logic        dmemAck;

  modport master (output dmemReq, dmemWe, dmemAddr, dmemWData, input dmemRData, dmemAck);
  modport slave  (input dmemReq, dmemWe, dmemAddr, dmemWData, output dmemRData, dmemAck);
endinterface

// File: rtl/mem_access_unit.sv
// Memory-stage access controller: runs req/ack data-memory transactions for loads and stores,
// stalls the front of the pipeline while one is outstanding and feeds the MEM/WB registers.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     memReadIn,
  input  logic                     memWriteIn,
  input  logic                     memToRegIn,
  input  logic                     regWriteIn,
  input  logic [63:0]              addrIn,
  input  logic [63:0]              writeDataIn,
  input  logic [4:0]               writeRegIn,
  mem_access_unit_if.master        dmem,
  output logic                     stall,
  output logic [63:0]              readDataOut,
  output logic [63:0]              aluResultOut,
  output logic [4:0]               writeRegOut,
  output logic                     regWriteOut,
  output logic                     memToRegOut,
  output logic                     alignFault,
  output logic                     timeoutFault
);

  typedef enum logic {IDLE, WAIT} stateT;

  localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT - 1);

  stateT      state, nextState;
  logic [7:0] counter;
  logic [4:0] latchedWriteReg;
  logic       latchedMemToReg, latchedRegWrite;
  logic       access, aligned, timeUp;
  logic       passThru, alignErr, startReq, complete, abort;

  assign access  = memReadIn | memWriteIn;
  assign aligned = (addrIn[2:0] == 3'b000);
  assign timeUp  = (counter == LAST_COUNT);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(negedge clock) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (access && aligned) nextState = WAIT;
      WAIT:    if (dmem.dmemAck || timeUp) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // NOTE: every signal gets a default first so no path through the case infers a latch.
  always_comb begin
    stall    = 1'b0;
    passThru = 1'b0;
    alignErr = 1'b0;
    startReq = 1'b0;
    complete = 1'b0;
    abort    = 1'b0;
    unique case (state)
      IDLE: begin
        if (!access)       passThru = 1'b1;
        else if (!aligned) alignErr = 1'b1;
        else begin
          startReq = 1'b1;
          stall    = 1'b1;
        end
      end
      WAIT: begin
        // An ack arriving on the last allowed cycle still completes the access.
        if (dmem.dmemAck) complete = 1'b1;
        else if (timeUp)  abort    = 1'b1;
        else              stall    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(negedge clock) begin
    if (reset) begin
      dmem.dmemReq    <= 1'b0;
      dmem.dmemWe     <= 1'b0;
      dmem.dmemAddr   <= '0;
      dmem.dmemWData  <= '0;
      counter         <= '0;
      latchedWriteReg <= '0;
      latchedMemToReg <= 1'b0;
      latchedRegWrite <= 1'b0;
      readDataOut     <= '0;
      aluResultOut    <= '0;
      writeRegOut     <= '0;
      regWriteOut     <= 1'b0;
      memToRegOut     <= 1'b0;
      alignFault      <= 1'b0;
      timeoutFault    <= 1'b0;
    end else begin
      alignFault   <= alignErr;
      timeoutFault <= abort;
      // MEM/WB sees a bubble unless an instruction actually leaves the stage this edge.
      regWriteOut  <= 1'b0;
      memToRegOut  <= 1'b0;

      if (passThru) begin
        aluResultOut <= addrIn;
        writeRegOut  <= writeRegIn;
        regWriteOut  <= regWriteIn;
        memToRegOut  <= memToRegIn;
        readDataOut  <= '0;
      end

      if (startReq) begin
        dmem.dmemReq    <= 1'b1;
        dmem.dmemWe     <= memWriteIn;
        dmem.dmemAddr   <= addrIn;
        dmem.dmemWData  <= writeDataIn;
        latchedWriteReg <= writeRegIn;
        latchedMemToReg <= memToRegIn;
        latchedRegWrite <= regWriteIn;
        counter         <= '0;
      end

      if (complete) begin
        readDataOut  <= dmem.dmemWe ? 64'd0 : dmem.dmemRData;
        aluResultOut <= dmem.dmemAddr;
        writeRegOut  <= latchedWriteReg;
        memToRegOut  <= latchedMemToReg;
        regWriteOut  <= latchedRegWrite & ~dmem.dmemWe;
        dmem.dmemReq <= 1'b0;
      end

      if (abort) dmem.dmemReq <= 1'b0;

      if (state == WAIT && !complete && !abort) counter <= counter + 8'd1;
    end
  end

endmodule
